fp32_pack: RTL and testbench

- Final stage of the single-precision multiplier datapath; the inverse of the unpack stage.
- Takes the sign, the biased exponent sum and the raw 48-bit mantissa product, then normalizes, rounds (round-to-nearest-even) and packs them into an IEEE-754 binary32 word.
- Iterative: normalization uses a one-bit-per-cycle shifter under an FSM.
- Uses a valid/ready handshake on both sides, so it sits between the multiplier array and the result register/consumer.

---
 rtl/fp32_pack.sv | 140 ++++++++++++++
 tb/tb_fp32_pack.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fp32_pack.sv
// Final stage of the fp32 multiplier: normalizes the raw 48-bit significand product,
// rounds to nearest-even and packs the sign, exponent and fraction into a binary32 word.
module fp32_pack #(
  parameter int          EXP_W = 10,
  parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [47:0]      in_mant,
  input  logic             in_nan,
  input  logic             in_inf,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      output_z,
  output logic             out_inexact
);

  // state | meaning
  // IDLE  | waiting for an operand bundle, in_ready high
  // NORM  | one-bit-per-cycle normalization of the mantissa
  // ROUND | round-to-nearest-even and pack
  // DONE  | result held until the consumer takes it
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  localparam logic signed [EXP_W-1:0] ZERO    = '0;
  localparam logic signed [EXP_W-1:0] ONE     = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_MAX = EXP_W'(255);

  state_t                  state_q;
  logic                    sign_q;
  logic signed [EXP_W-1:0] exp_q;
  logic [47:0]             mant_q;
  logic                    sticky_q;
  logic                    out_valid_q;
  logic [31:0]             z_q;
  logic                    inexact_q;

  logic [22:0]             frac_d;
  logic                    guard_d;
  logic                    sticky_d;
  logic                    round_up_d;
  logic [22:0]             frac_rnd_d;
  logic signed [EXP_W-1:0] exp_rnd_d;

  always_comb begin
    frac_d     = mant_q[45:23];
    guard_d    = mant_q[22];
    sticky_d   = sticky_q | (|mant_q[21:0]);
    round_up_d = guard_d & (sticky_d | frac_d[0]);
    frac_rnd_d = frac_d + {22'b0, round_up_d};
    // an all-ones fraction rounding up carries into the exponent
    exp_rnd_d  = exp_q + ((round_up_d && (&frac_d)) ? ONE : ZERO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= ZERO;
      mant_q      <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      inexact_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q    <= in_sign;
            exp_q     <= in_exp;
            mant_q    <= in_mant;
            sticky_q  <= 1'b0;
            inexact_q <= 1'b0;
            if (in_nan) begin
              z_q     <= QNAN;
              state_q <= DONE;
            end else if (in_inf) begin
              z_q     <= {in_sign, 8'hFF, 23'h0};
              state_q <= DONE;
            end else if (in_zero) begin
              z_q     <= {in_sign, 31'h0};
              state_q <= DONE;
            end else begin
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (mant_q == 48'h0) begin
            z_q         <= {sign_q, 31'h0};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (mant_q[47]) begin
            sticky_q <= sticky_q | mant_q[0];
            mant_q   <= mant_q >> 1;
            exp_q    <= exp_q + ONE;
          end else if (exp_q <= ZERO) begin
            z_q         <= {sign_q, 31'h0};
            inexact_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (mant_q[46]) begin
            state_q <= ROUND;
          end else begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - ONE;
          end
        end
        ROUND: begin
          if (exp_rnd_d >= EXP_MAX) z_q <= {sign_q, 8'hFF, 23'h0};
          else                      z_q <= {sign_q, exp_rnd_d[7:0], frac_rnd_d};
          inexact_q   <= guard_d | sticky_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // specials arrive here with out_valid low and raise it one cycle later
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign output_z    = z_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_fp32_pack.sv
// Directed self-checking bench for fp32_pack: results, inexact flag, latency,
// output hold under backpressure and reset abort.
module tb_fp32_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic        in_nan, in_inf, in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] output_z;
  logic        out_inexact;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp32_pack #(.EXP_W(10), .QNAN(32'h7FC0_0000)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_z(output_z), .out_inexact(out_inexact)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] m,
                       input logic nan, input logic inf, input logic zero);
    in_sign = s; in_exp = e; in_mant = m;
    in_nan = nan; in_inf = inf; in_zero = zero;
    in_valid = 1'b1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
  endtask

  // called one step after a clock edge; waits for out_valid with a cycle budget
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [9:0] e,
                        input logic [47:0] m, input logic nan, input logic inf,
                        input logic zero, input logic [31:0] want_z,
                        input logic want_inx, input int want_lat);
    int cyc;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    drive(s, e, m, nan, inf, zero);
    @(posedge clk); #1;
    idle_inputs();
    wait_valid(cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'(want_lat));
    chk({tag, "_z"},   64'(output_z), 64'(want_z));
    chk({tag, "_inx"}, 64'(out_inexact), 64'(want_inx));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_vld_fall"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; out_ready = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_z",   64'(output_z), 64'd0);
    chk("rst_inx", 64'(out_inexact), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //     tag          s  exp   mant                             nan inf zero  want_z        inx lat
    run_op("one",       0, 127,  48'h1 << 46,                     0,  0,  0,    32'h3F800000, 0,  2);
    run_op("onept5sq",  0, 127,  48'h900000000000,                0,  0,  0,    32'h40100000, 0,  3);
    run_op("rne_tie",   0, 127,  (48'h1 << 46) | (48'h1 << 22),   0,  0,  0,    32'h3F800000, 1,  2);
    run_op("rne_odd",   0, 127,  (48'h1 << 46) | (48'h3 << 22),   0,  0,  0,    32'h3F800002, 1,  2);
    run_op("ovf",       0, 254,  48'hFFFFFFFFFFFF,                0,  0,  0,    32'h7F800000, 1,  3);
    run_op("unf",       1, 1,    48'h1 << 45,                     0,  0,  0,    32'h80000000, 1,  2);
    run_op("lshift2",   0, 130,  48'h1 << 44,                     0,  0,  0,    32'h40000000, 0,  4);
    run_op("lshift46",  0, 200,  48'h1,                           0,  0,  0,    32'h4D000000, 0,  48);
    run_op("mant0",     1, 127,  48'h0,                           0,  0,  0,    32'h80000000, 0,  1);
    run_op("nan",       0, 127,  48'h1 << 46,                     1,  0,  0,    32'h7FC00000, 0,  1);
    run_op("inf_neg",   1, 127,  48'h1 << 46,                     0,  1,  0,    32'hFF800000, 0,  1);
    run_op("nan_inf",   1, 127,  48'h1 << 46,                     1,  1,  0,    32'h7FC00000, 0,  1);
    run_op("zero_neg",  1, 127,  48'h1 << 46,                     0,  0,  1,    32'h80000000, 0,  1);

    // backpressure: result must hold and new bundles must be refused
    drive(0, 127, 48'h1 << 46, 0, 0, 0);
    @(posedge clk); #1;
    idle_inputs();
    wait_valid(cyc);
    chk("bp_lat", 64'(cyc), 64'd2);
    for (int i = 0; i < 5; i++) begin
      drive(1, 200, 48'h1 << 47, 0, 1, 0);
      @(posedge clk); #1;
      chk("bp_z",   64'(output_z), 64'h3F800000);
      chk("bp_vld", 64'(out_valid), 64'd1);
      chk("bp_rdy", 64'(in_ready), 64'd0);
    end
    idle_inputs();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_vld_fall", 64'(out_valid), 64'd0);
    chk("bp_rdy_back", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_accept", 64'(out_valid), 64'd0);

    // reset while normalizing aborts the operation
    drive(0, 200, 48'h1, 0, 0, 0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("nrm_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("nrm_rst_rdy", 64'(in_ready), 64'd1);
    chk("nrm_rst_vld", 64'(out_valid), 64'd0);
    chk("nrm_rst_z",   64'(output_z), 64'd0);
    repeat (60) @(posedge clk);
    #1;
    chk("nrm_rst_quiet", 64'(out_valid), 64'd0);
    run_op("after_rst", 0, 127, 48'h900000000000, 0, 0, 0, 32'h40100000, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
